// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg -- configurable asynchronous serial receiver.
//
// Receives frames of DATA_BITS data bits (LSB first), an optional parity
// bit (PARITY: 0 none, 1 odd, 2 even) and STOP_BITS stop bits. Each bit is
// decided by a 2-of-3 majority vote over the synchronized line. Completed
// frames land in a holding register that is handed off with a valid/ready
// handshake; a frame that completes while the register is still full and
// not being taken is dropped and flagged with o_Overrun. An all-zero frame
// whose first stop bit is also zero is reported as a line break instead of
// being stored.
//
// Ports:
//   i_Clock      rising-edge clock
//   i_Reset      synchronous active-high reset
//   i_Rx_Serial  asynchronous serial input, idle high
//   i_Rx_Ready   consumer ready
//   o_Rx_Valid   holding register contains a frame
//   o_Rx_Data    received data of the held frame
//   o_Parity_Err parity mismatch of the held frame (0 when PARITY=0)
//   o_Frame_Err  a stop bit of the held frame was sampled low
//   o_Overrun    one-cycle pulse: completed frame dropped
//   o_Break      one-cycle pulse: break detected
module uart_rx_cfg #(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int BAUDRATE    = 115200,
  parameter int DATA_BITS   = 8,
  parameter int PARITY      = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic                 i_Clock,
  input  logic                 i_Reset,
  input  logic                 i_Rx_Serial,
  input  logic                 i_Rx_Ready,
  output logic                 o_Rx_Valid,
  output logic [DATA_BITS-1:0] o_Rx_Data,
  output logic                 o_Parity_Err,
  output logic                 o_Frame_Err,
  output logic                 o_Overrun,
  output logic                 o_Break
);

  localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUDRATE;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT) + 1;

  localparam logic [CNT_W-1:0] HALF_CNT  = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0]       LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic             LAST_STOP = 1'(STOP_BITS - 1);
  localparam logic             ODD_PAR   = (PARITY == 1);

  generate
    if (CLKS_PER_BIT < 8) begin : g_bad_clks_per_bit
      $error("uart_rx_cfg: CLK_FREQ_HZ/BAUDRATE must be at least 8");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
      $error("uart_rx_cfg: DATA_BITS must be in 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
      $error("uart_rx_cfg: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
      $error("uart_rx_cfg: STOP_BITS must be 1 or 2");
    end
  endgenerate

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_WAIT_IDLE
  } state_t;

  // 2-of-3 majority over three consecutive line samples.
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // 1 when the data plus received parity bit disagree with the configured
  // parity sense.
  function automatic logic calc_par_err(input logic [DATA_BITS-1:0] d,
                                        input logic                 p);
    return (^d) ^ p ^ ODD_PAR;
  endfunction

  // Synchronizer and sample history
  logic sync_p0;
  logic sync_p1;
  logic hist_p2;
  logic hist_p3;
  logic bit_vote;

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
      hist_p2 <= 1'b1;
      hist_p3 <= 1'b1;
    end else begin
      sync_p0 <= i_Rx_Serial;
      sync_p1 <= sync_p0;
      hist_p2 <= sync_p1;
      hist_p3 <= hist_p2;
    end
  end

  assign bit_vote = maj3(sync_p1, hist_p2, hist_p3);

  // Frame FSM
  state_t               state, state_nxt;
  logic [CNT_W-1:0]     cnt, cnt_nxt;
  logic [3:0]           bit_idx, bit_idx_nxt;
  logic                 stop_idx, stop_idx_nxt;
  logic [DATA_BITS-1:0] shreg, shreg_nxt;
  logic                 par_err_r, par_err_nxt;
  logic                 frm_err_r, frm_err_nxt;
  logic                 zero_r, zero_nxt;
  logic                 load_frame;
  logic                 brk_det;

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      bit_idx  <= bit_idx_nxt;
      stop_idx <= stop_idx_nxt;
    end
  end

  // Frame accumulators are re-initialised on every accepted start bit, so
  // they carry no reset.
  always_ff @(posedge i_Clock) begin
    shreg     <= shreg_nxt;
    par_err_r <= par_err_nxt;
    frm_err_r <= frm_err_nxt;
    zero_r    <= zero_nxt;
  end

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    bit_idx_nxt  = bit_idx;
    stop_idx_nxt = stop_idx;
    shreg_nxt    = shreg;
    par_err_nxt  = par_err_r;
    frm_err_nxt  = frm_err_r;
    zero_nxt     = zero_r;
    load_frame   = 1'b0;
    brk_det      = 1'b0;

    case (state)
      ST_IDLE: begin
        if (!sync_p1) begin
          cnt_nxt   = '0;
          state_nxt = ST_START;
        end
      end

      ST_START: begin
        if (cnt == HALF_CNT) begin
          if (!bit_vote) begin
            cnt_nxt     = '0;
            bit_idx_nxt = '0;
            par_err_nxt = 1'b0;
            frm_err_nxt = 1'b0;
            zero_nxt    = 1'b1;
            state_nxt   = ST_DATA;
          end else begin
            // Too short to be a start bit: treat as a glitch.
            state_nxt = ST_IDLE;
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end

      ST_DATA: begin
        if (cnt == LAST_CNT) begin
          cnt_nxt   = '0;
          shreg_nxt = {bit_vote, shreg[DATA_BITS-1:1]};
          if (bit_vote) zero_nxt = 1'b0;
          if (bit_idx == LAST_DATA) begin
            bit_idx_nxt  = '0;
            stop_idx_nxt = 1'b0;
            state_nxt    = (PARITY != 0) ? ST_PARITY : ST_STOP;
          end else begin
            bit_idx_nxt = bit_idx + 4'd1;
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end

      ST_PARITY: begin
        if (cnt == LAST_CNT) begin
          cnt_nxt      = '0;
          par_err_nxt  = calc_par_err(shreg, bit_vote);
          if (bit_vote) zero_nxt = 1'b0;
          stop_idx_nxt = 1'b0;
          state_nxt    = ST_STOP;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end

      ST_STOP: begin
        if (cnt == LAST_CNT) begin
          cnt_nxt = '0;
          if (!bit_vote) frm_err_nxt = 1'b1;
          if (!stop_idx && zero_r && !bit_vote) begin
            // Everything low through the first stop bit: a break, not data.
            brk_det   = 1'b1;
            state_nxt = ST_WAIT_IDLE;
          end else if (stop_idx == LAST_STOP) begin
            load_frame = 1'b1;
            state_nxt  = bit_vote ? ST_IDLE : ST_WAIT_IDLE;
          end else begin
            stop_idx_nxt = 1'b1;
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end

      ST_WAIT_IDLE: begin
        // A low line here belongs to the previous frame or break, never to
        // a new start bit.
        if (sync_p1) state_nxt = ST_IDLE;
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Holding register and handshake
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      o_Rx_Valid   <= 1'b0;
      o_Rx_Data    <= '0;
      o_Parity_Err <= 1'b0;
      o_Frame_Err  <= 1'b0;
      o_Overrun    <= 1'b0;
      o_Break      <= 1'b0;
    end else begin
      o_Overrun <= 1'b0;
      o_Break   <= brk_det;
      if (load_frame) begin
        // A transfer in the same cycle frees the register for the new frame.
        if (!o_Rx_Valid || i_Rx_Ready) begin
          o_Rx_Valid   <= 1'b1;
          o_Rx_Data    <= shreg;
          o_Parity_Err <= par_err_r;
          o_Frame_Err  <= frm_err_nxt;
        end else begin
          o_Overrun <= 1'b1;
        end
      end else if (o_Rx_Valid && i_Rx_Ready) begin
        o_Rx_Valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Testbench for uart_rx_cfg. Three instances: defaults (434 clocks/bit),
// even parity at 16 clocks/bit, and 9 data bits with 2 stop bits at 16
// clocks/bit. Expected frames are queued when driven and compared when the
// DUT transfers them.
module tb_uart_rx_cfg;

  localparam int CPB_A = 434;
  localparam int CPB_F = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b, rst_c;
  logic rx_a, rx_b, rx_c;
  logic rdy_a, rdy_b, rdy_c;

  logic       vld_a, perr_a, ferr_a, ovr_a, brk_a;
  logic [7:0] data_a;
  logic       vld_b, perr_b, ferr_b, ovr_b, brk_b;
  logic [7:0] data_b;
  logic       vld_c, perr_c, ferr_c, ovr_c, brk_c;
  logic [8:0] data_c;

  uart_rx_cfg u_a (
    .i_Clock(clk), .i_Reset(rst_a), .i_Rx_Serial(rx_a), .i_Rx_Ready(rdy_a),
    .o_Rx_Valid(vld_a), .o_Rx_Data(data_a), .o_Parity_Err(perr_a),
    .o_Frame_Err(ferr_a), .o_Overrun(ovr_a), .o_Break(brk_a)
  );

  uart_rx_cfg #(.CLK_FREQ_HZ(1_843_200), .BAUDRATE(115200), .PARITY(2)) u_b (
    .i_Clock(clk), .i_Reset(rst_b), .i_Rx_Serial(rx_b), .i_Rx_Ready(rdy_b),
    .o_Rx_Valid(vld_b), .o_Rx_Data(data_b), .o_Parity_Err(perr_b),
    .o_Frame_Err(ferr_b), .o_Overrun(ovr_b), .o_Break(brk_b)
  );

  uart_rx_cfg #(.CLK_FREQ_HZ(1_843_200), .BAUDRATE(115200), .DATA_BITS(9),
                .STOP_BITS(2)) u_c (
    .i_Clock(clk), .i_Reset(rst_c), .i_Rx_Serial(rx_c), .i_Rx_Ready(rdy_c),
    .o_Rx_Valid(vld_c), .o_Rx_Data(data_c), .o_Parity_Err(perr_c),
    .o_Frame_Err(ferr_c), .o_Overrun(ovr_c), .o_Break(brk_c)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard entries: [10]=frame err, [9]=parity err, [8:0]=data
  logic [15:0] exp_a[$];
  logic [15:0] exp_b[$];
  logic [15:0] exp_c[$];
  logic [15:0] mon_e;
  int ovr_cnt_a = 0, ovr_cnt_b = 0, ovr_cnt_c = 0;
  int brk_cnt_a = 0, brk_cnt_b = 0, brk_cnt_c = 0;

  always @(negedge clk) begin
    #1;
    if (vld_a && rdy_a) begin
      if (exp_a.size() == 0) check("a_unexpected_frame", 32'(data_a), 32'h1_0000);
      else begin
        mon_e = exp_a.pop_front();
        check("a_data", 32'(data_a), 32'(mon_e[8:0]));
        check("a_perr", 32'(perr_a), 32'(mon_e[9]));
        check("a_ferr", 32'(ferr_a), 32'(mon_e[10]));
      end
    end
    if (vld_b && rdy_b) begin
      if (exp_b.size() == 0) check("b_unexpected_frame", 32'(data_b), 32'h1_0000);
      else begin
        mon_e = exp_b.pop_front();
        check("b_data", 32'(data_b), 32'(mon_e[8:0]));
        check("b_perr", 32'(perr_b), 32'(mon_e[9]));
        check("b_ferr", 32'(ferr_b), 32'(mon_e[10]));
      end
    end
    if (vld_c && rdy_c) begin
      if (exp_c.size() == 0) check("c_unexpected_frame", 32'(data_c), 32'h1_0000);
      else begin
        mon_e = exp_c.pop_front();
        check("c_data", 32'(data_c), 32'(mon_e[8:0]));
        check("c_perr", 32'(perr_c), 32'(mon_e[9]));
        check("c_ferr", 32'(ferr_c), 32'(mon_e[10]));
      end
    end
    if (ovr_a) ovr_cnt_a++;
    if (ovr_b) ovr_cnt_b++;
    if (ovr_c) ovr_cnt_c++;
    if (brk_a) brk_cnt_a++;
    if (brk_b) brk_cnt_b++;
    if (brk_c) brk_cnt_c++;
  end

  function automatic int cpb_of(input int which);
    return (which == 0) ? CPB_A : CPB_F;
  endfunction

  function automatic int nb_of(input int which);
    return (which == 2) ? 9 : 8;
  endfunction

  function automatic bit has_par(input int which);
    return which == 1;
  endfunction

  function automatic int ns_of(input int which);
    return (which == 2) ? 2 : 1;
  endfunction

  function automatic int qsize(input int which);
    case (which)
      0:       return exp_a.size();
      1:       return exp_b.size();
      default: return exp_c.size();
    endcase
  endfunction

  task automatic set_line(input int which, input logic v);
    case (which)
      0:       rx_a = v;
      1:       rx_b = v;
      default: rx_c = v;
    endcase
  endtask

  task automatic set_rst(input int which, input logic v);
    case (which)
      0:       rst_a = v;
      1:       rst_b = v;
      default: rst_c = v;
    endcase
  endtask

  task automatic set_rdy(input int which, input logic v);
    case (which)
      0:       rdy_a = v;
      1:       rdy_b = v;
      default: rdy_c = v;
    endcase
  endtask

  task automatic push_exp(input int which, input logic [8:0] d,
                          input logic p, input logic f);
    logic [15:0] e;
    e = {5'b0, f, p, d};
    case (which)
      0:       exp_a.push_back(e);
      1:       exp_b.push_back(e);
      default: exp_c.push_back(e);
    endcase
  endtask

  task automatic check_cleared(input int which);
    case (which)
      0: begin
        check("a_rst_valid", 32'(vld_a), 0);  check("a_rst_data", 32'(data_a), 0);
        check("a_rst_perr", 32'(perr_a), 0);  check("a_rst_ferr", 32'(ferr_a), 0);
        check("a_rst_ovr", 32'(ovr_a), 0);    check("a_rst_brk", 32'(brk_a), 0);
      end
      1: begin
        check("b_rst_valid", 32'(vld_b), 0);  check("b_rst_data", 32'(data_b), 0);
        check("b_rst_perr", 32'(perr_b), 0);  check("b_rst_ferr", 32'(ferr_b), 0);
        check("b_rst_ovr", 32'(ovr_b), 0);    check("b_rst_brk", 32'(brk_b), 0);
      end
      default: begin
        check("c_rst_valid", 32'(vld_c), 0);  check("c_rst_data", 32'(data_c), 0);
        check("c_rst_perr", 32'(perr_c), 0);  check("c_rst_ferr", 32'(ferr_c), 0);
        check("c_rst_ovr", 32'(ovr_c), 0);    check("c_rst_brk", 32'(brk_c), 0);
      end
    endcase
  endtask

  // Drives one frame. spike_bit: frame bit index (0 = start) that gets a
  // one-cycle inversion at its sample point. rst_bit: frame bit index where
  // reset is pulsed and the frame abandoned. Use -1 to disable either.
  task automatic send_frame(input int which, input logic [8:0] data,
                            input logic par_bit, input logic stop_val,
                            input int spike_bit, input int rst_bit);
    logic bits[$];
    int   cpb;
    bit   aborted;
    cpb     = cpb_of(which);
    aborted = 1'b0;
    bits.push_back(1'b0);
    for (int i = 0; i < nb_of(which); i++) bits.push_back(data[i]);
    if (has_par(which)) bits.push_back(par_bit);
    bits.push_back(stop_val);
    if (ns_of(which) == 2) bits.push_back(1'b1);
    for (int j = 0; j < bits.size() && !aborted; j++) begin
      for (int c = 0; c < cpb && !aborted; c++) begin
        if (j == rst_bit && c == cpb / 2) begin
          set_rst(which, 1'b1);
          repeat (2) @(negedge clk);
          check_cleared(which);
          set_rst(which, 1'b0);
          set_line(which, 1'b1);
          aborted = 1'b1;
        end else begin
          set_line(which, bits[j] ^ (j == spike_bit && c == (cpb - 1) / 2 + 1));
          @(negedge clk);
        end
      end
    end
    set_line(which, 1'b1);
    repeat (2 * cpb) @(negedge clk);
  endtask

  task automatic wait_drain(input int which, input string tag);
    for (int i = 0; i < 4 * cpb_of(which); i++) begin
      if (qsize(which) == 0) break;
      @(negedge clk);
    end
    check(tag, 32'(qsize(which)), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rx_a = 1'b1;  rx_b = 1'b1;  rx_c = 1'b1;
    rdy_a = 1'b1; rdy_b = 1'b1; rdy_c = 1'b1;
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    repeat (3) @(negedge clk);
    check_cleared(0);
    check_cleared(1);
    check_cleared(2);
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    repeat (5) @(negedge clk);

    // Default instance: plain frame
    push_exp(0, 9'h0A5, 1'b0, 1'b0);
    send_frame(0, 9'h0A5, 1'b0, 1'b1, -1, -1);
    wait_drain(0, "a_drain_a5");

    // Short low glitch must not start a frame
    set_line(0, 1'b0);
    repeat (100) @(negedge clk);
    set_line(0, 1'b1);
    repeat (2 * CPB_A) @(negedge clk);
    check("a_glitch_valid", 32'(vld_a), 0);
    push_exp(0, 9'h03C, 1'b0, 1'b0);
    send_frame(0, 9'h03C, 1'b0, 1'b1, -1, -1);
    wait_drain(0, "a_drain_3c");

    // One-cycle spike on data bit 2 at its sample point
    push_exp(0, 9'h096, 1'b0, 1'b0);
    send_frame(0, 9'h096, 1'b0, 1'b1, 3, -1);
    wait_drain(0, "a_drain_spike");

    // Low stop bit
    push_exp(0, 9'h055, 1'b0, 1'b1);
    send_frame(0, 9'h055, 1'b0, 1'b0, -1, -1);
    wait_drain(0, "a_drain_ferr");

    // Break: line low for 20 bit times
    set_line(0, 1'b0);
    repeat (20 * CPB_A) @(negedge clk);
    check("a_break_count_low", 32'(brk_cnt_a), 1);
    check("a_break_valid", 32'(vld_a), 0);
    set_line(0, 1'b1);
    repeat (2 * CPB_A) @(negedge clk);
    check("a_break_count_idle", 32'(brk_cnt_a), 1);

    // Overrun with consumer stalled
    set_rdy(0, 1'b0);
    push_exp(0, 9'h011, 1'b0, 1'b0);
    send_frame(0, 9'h011, 1'b0, 1'b1, -1, -1);
    send_frame(0, 9'h022, 1'b0, 1'b1, -1, -1);
    check("a_ovr_valid", 32'(vld_a), 1);
    check("a_ovr_held_data", 32'(data_a), 32'h11);
    check("a_ovr_count", 32'(ovr_cnt_a), 1);
    set_rdy(0, 1'b1);
    wait_drain(0, "a_drain_ovr");
    repeat (2) @(negedge clk);
    check("a_valid_fell", 32'(vld_a), 0);

    // Even parity instance
    push_exp(1, 9'h007, 1'b1, 1'b0);
    send_frame(1, 9'h007, 1'b0, 1'b1, -1, -1);
    push_exp(1, 9'h007, 1'b0, 1'b0);
    send_frame(1, 9'h007, 1'b1, 1'b1, -1, -1);
    wait_drain(1, "b_drain_parity");

    // 9 data bits, 2 stop bits
    push_exp(2, 9'h1A5, 1'b0, 1'b0);
    send_frame(2, 9'h1A5, 1'b0, 1'b1, -1, -1);
    wait_drain(2, "c_drain_1a5");
    set_rdy(2, 1'b0);
    send_frame(2, 9'h0AA, 1'b0, 1'b1, -1, -1);
    check("c_held_valid", 32'(vld_c), 1);
    check("c_held_data", 32'(data_c), 32'h0AA);
    send_frame(2, 9'h155, 1'b0, 1'b1, -1, 5);
    set_rdy(2, 1'b1);
    push_exp(2, 9'h0F3, 1'b0, 1'b0);
    send_frame(2, 9'h0F3, 1'b0, 1'b1, -1, -1);
    wait_drain(2, "c_drain_0f3");

    check("b_ovr_count", 32'(ovr_cnt_b), 0);
    check("b_brk_count", 32'(brk_cnt_b), 0);
    check("c_ovr_count", 32'(ovr_cnt_c), 0);
    check("c_brk_count", 32'(brk_cnt_c), 0);
    check("a_ovr_count_final", 32'(ovr_cnt_a), 1);
    check("a_brk_count_final", 32'(brk_cnt_a), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_cfg.md
UART_RX_CFG -- requirements
Module: uart_rx_cfg

Interface
REQ-001 The block SHALL expose parameter CLK_FREQ_HZ, default 50_000_000, the i_Clock frequency in Hz.
REQ-002 The block SHALL expose parameter BAUDRATE, default 115200, the line bit rate.
REQ-003 The block SHALL expose parameter DATA_BITS, default 8, legal 5..9, the data bits per frame, LSB first.
REQ-004 The block SHALL expose parameter PARITY, default 0, where 0=none, 1=odd and 2=even.
REQ-005 The block SHALL expose parameter STOP_BITS, default 1, legal 1..2.
REQ-006 The block SHALL have port i_Clock, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-007 The block SHALL have port i_Reset, input, 1 bit: reset, synchronous and active-high.
REQ-008 The block SHALL have port i_Rx_Serial, input, 1 bit: the asynchronous serial line, idle high.
REQ-009 The block SHALL have port i_Rx_Ready, input, 1 bit: consumer ready.
REQ-010 The block SHALL have port o_Rx_Valid, output, 1 bit: the holding register contains a frame.
REQ-011 The block SHALL have port o_Rx_Data, output, DATA_BITS wide: the received data, bit 0 first on the line.
REQ-012 The block SHALL have port o_Parity_Err, output, 1 bit: parity mismatch for the held frame; always 0 when PARITY=0.
REQ-013 The block SHALL have port o_Frame_Err, output, 1 bit: a stop bit of the held frame sampled low.
REQ-014 The block SHALL have port o_Overrun, output, 1 bit: one-cycle pulse when a completed frame is dropped.
REQ-015 The block SHALL have port o_Break, output, 1 bit: one-cycle pulse on break detection.

Function
REQ-016 CLKS_PER_BIT SHALL equal CLK_FREQ_HZ/BAUDRATE using integer division; the bit counter SHALL be $clog2(CLKS_PER_BIT)+1 bits wide; CLKS_PER_BIT<8 SHALL be rejected at elaboration.
REQ-017 i_Rx_Serial SHALL pass through a two-flop synchronizer, both flops initialising to 1; all decisions SHALL use the synchronized value.
REQ-018 Every bit decision SHALL be the 2-of-3 majority of the synchronized line at the decision cycle and the two preceding cycles.
REQ-019 The FSM SHALL have the states IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
REQ-020 IDLE: when the line is low, the FSM SHALL clear the counter and go to START.
REQ-021 START: the decision SHALL be taken at counter==(CLKS_PER_BIT-1)/2; on majority low the FSM SHALL clear the counter and go to DATA; otherwise it SHALL go to IDLE as a glitch, with no outputs.
REQ-022 DATA, PARITY and STOP: the decision SHALL be taken at counter==CLKS_PER_BIT-1 and the counter SHALL then clear; DATA SHALL shift DATA_BITS bits, then go to PARITY if PARITY!=0, else to STOP.
REQ-023 In PARITY, the error bit SHALL be computed as the XOR of the data and parity bits, inverted for odd parity, and SHALL be 1 on mismatch.
REQ-024 In STOP, STOP_BITS bits SHALL be sampled, and any low stop bit SHALL set the frame error; after the last stop-bit decision the FSM SHALL go to IDLE if the line is high, else to WAIT_IDLE.
REQ-025 Break detection SHALL fire when all data bits, the parity bit if present and the first stop bit are 0: o_Break SHALL pulse 1 cycle after the decision, the frame SHALL NOT be loaded, and the FSM SHALL go to WAIT_IDLE.
REQ-026 WAIT_IDLE SHALL go to IDLE only after the synchronized line has been high for one cycle; no start bit SHALL be detected in WAIT_IDLE.
REQ-027 Non-break frames, errored or not, SHALL load the holding register (data plus error flags) and set o_Rx_Valid on the cycle after the last stop decision.
REQ-028 A transfer SHALL occur on any cycle where o_Rx_Valid and i_Rx_Ready are both 1; o_Rx_Valid SHALL fall on the next cycle unless a new frame loads that same cycle.
REQ-029 If a frame completes while o_Rx_Valid=1 and i_Rx_Ready=0, it SHALL be dropped, the held data SHALL be unchanged, and o_Overrun SHALL pulse for 1 cycle.
REQ-030 If a frame completes in the same cycle as a transfer, the new frame SHALL load, o_Rx_Valid SHALL stay 1, and no overrun SHALL occur.
REQ-031 o_Rx_Data and the error flags SHALL be stable while o_Rx_Valid=1 and no transfer occurs.

Reset
REQ-032 While i_Reset=1 at a clock edge, the FSM SHALL be in IDLE, the counters SHALL be 0, the synchronizer SHALL be 1, and o_Rx_Valid, o_Rx_Data, o_Parity_Err, o_Frame_Err, o_Overrun and o_Break SHALL all be 0.
REQ-033 Reset asserted mid-frame SHALL abandon the frame with no output pulse; the first clean frame after release SHALL be received correctly.

Verification
REQ-034 Defaults (CLKS_PER_BIT=434), ready=1, frame 0xA5 -> o_Rx_Valid 1 cycle, o_Rx_Data=0xA5, all error flags 0.
REQ-035 PARITY=2, frame 0x07 with parity bit 0 -> o_Rx_Data=0x07, o_Parity_Err=1; the same frame with parity bit 1 -> o_Parity_Err=0.
REQ-036 100-cycle low glitch on an idle line -> no o_Rx_Valid; a following 0x3C frame -> received as 0x3C; a 1-cycle spike at a data sample point -> ignored by the majority vote.
REQ-037 Frame 0x55 with stop bit low -> o_Frame_Err=1 and data 0x55; line low for 20 bit times -> exactly one o_Break pulse, no o_Rx_Valid, and no new frame until the line returns high.
REQ-038 Ready=0, frames 0x11 then 0x22 -> data held at 0x11 and one o_Overrun pulse; raise ready -> 0x11 transfers and o_Rx_Valid falls.
REQ-039 DATA_BITS=9, STOP_BITS=2, frame 0x1A5 -> o_Rx_Data=0x1A5; i_Reset pulsed during data bit 4 -> all outputs 0, next frame 0x0F3 received correctly.
